// File: rtl/core_isa_pkg.sv
// core_isa_pkg
//   Architectural constants shared by the core's decode and memory stages.
//   ISA_WORD_BYTES : byte stride between consecutive block-transfer words.
package core_isa_pkg;

    localparam int ISA_WORD_BYTES = 4;

endpackage : core_isa_pkg

// File: rtl/core_uarch_pkg.sv
// core_uarch_pkg
//   Micro-architectural types shared between the load/store decode stage and
//   the load/store sequencer.
//   ldst_size   : memory access width.
//   ldst_decode : one decoded load/store transfer, as handed to the sequencer.
//   ldst_state  : sequencer control state.
package core_uarch_pkg;

    // Upper bound for register-file size carried by the decode record.
    // Sequencers configured with fewer registers use the low slice.
    localparam int LDST_MAX_REGS  = 16;
    localparam int LDST_REG_IDX_W = $clog2(LDST_MAX_REGS);

    typedef enum logic [1:0] {
        LDST_BYTE = 2'd0,
        LDST_HALF = 2'd1,
        LDST_WORD = 2'd2
    } ldst_size;

    typedef struct packed {
        logic [LDST_REG_IDX_W-1:0] rn;
        logic [LDST_REG_IDX_W-1:0] rd;
        ldst_size                  size;
        logic                      load;
        logic                      increment;
        logic                      writeback;
        logic                      sign_extend;
        logic                      pre_indexed;
        logic                      unprivileged;
        logic                      user_regs;
        logic [LDST_MAX_REGS-1:0]  regs;
    } ldst_decode;

    typedef enum logic [1:0] {
        LDST_IDLE = 2'd0,
        LDST_XFER = 2'd1,
        LDST_DONE = 2'd2
    } ldst_state;

endpackage : core_uarch_pkg

// File: rtl/core_ldst_pick_lowest.sv
// core_ldst_pick_lowest
//   Combinational helper: finds the lowest set bit of a register mask.
//   Ports:
//     mask : input register mask (N bits).
//     idx  : index of the lowest set bit (0 when mask is empty).
//     rest : mask with that lowest set bit cleared.
module core_ldst_pick_lowest #(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic [N-1:0] rest
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = W'(i);
            end
        end
    end

    // Subtracting one borrows through the trailing zeros and flips exactly
    // the lowest set bit, so the AND removes only that bit.
    assign rest = mask & (mask - N'(1));

endmodule : core_ldst_pick_lowest

// File: rtl/core_ldst_sequencer.sv
// core_ldst_sequencer
//   Turns one decoded load/store transfer into a sequence of memory requests
//   over a valid/ready handshake, then reports the base-register writeback.
//   Single transfers issue one beat; block transfers issue one beat per set
//   bit of the register mask in ascending register order.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset.
//     start/start_ready   : transfer hand-off from decode (ready only in IDLE).
//     multiple, decode,
//     base, offset        : the transfer being handed over.
//     mem_*               : memory request channel (mem_valid/mem_ready).
//     done                : one-cycle completion pulse.
//     wb_valid/wb_reg/
//     wb_value            : base-register writeback, qualified by done.
module core_ldst_sequencer
    import core_uarch_pkg::*;
    import core_isa_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int NUM_REGS   = 16,
    parameter  int WORD_BYTES = ISA_WORD_BYTES,
    localparam int REG_W      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              start,
    output logic              start_ready,
    input  logic              multiple,
    input  ldst_decode        decode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,

    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output ldst_size          mem_size,
    output logic              mem_sign_extend,
    output logic              mem_user,
    output logic [REG_W-1:0]  mem_reg,
    output logic              mem_user_regs,

    output logic              done,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_reg,
    output logic [ADDR_W-1:0] wb_value
);

    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(WORD_BYTES);
    // WORD_BYTES is a power of two; this clears the sub-word address bits.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

    function automatic logic [REG_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [REG_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + (REG_W + 1)'(v[i]);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Latched transfer
    // ------------------------------------------------------------------
    ldst_state           state_reg;
    logic [NUM_REGS-1:0] mask_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   wb_value_reg;
    logic                wb_en_reg;
    logic [REG_W-1:0]    rn_reg;
    logic [REG_W-1:0]    rd_reg;
    ldst_size            size_reg;
    logic                load_reg;
    logic                sext_reg;
    logic                unpriv_reg;
    logic                user_regs_reg;
    logic                multiple_reg;

    // ------------------------------------------------------------------
    // Start-of-transfer address and writeback computation
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] regs_in;
    logic [REG_W:0]      reg_count;
    logic [ADDR_W-1:0]   block_span;
    logic [ADDR_W-1:0]   single_wb;
    logic [ADDR_W-1:0]   single_addr;
    logic [ADDR_W-1:0]   block_wb;
    logic [ADDR_W-1:0]   block_addr_raw;
    logic [ADDR_W-1:0]   block_addr;

    assign regs_in    = decode.regs[NUM_REGS-1:0];
    assign reg_count  = popcount(regs_in);
    assign block_span = STRIDE * ADDR_W'(reg_count);

    assign single_wb   = decode.increment ? (base + offset) : (base - offset);
    assign single_addr = decode.pre_indexed ? single_wb : base;

    assign block_wb = decode.increment ? (base + block_span) : (base - block_span);

    // The block always walks upward, so decrementing modes start at the
    // lowest address the block will touch.
    always_comb begin
        block_addr_raw = base;
        case ({decode.increment, decode.pre_indexed})
            2'b10:   block_addr_raw = base;
            2'b11:   block_addr_raw = base + STRIDE;
            2'b00:   block_addr_raw = base - block_span + STRIDE;
            default: block_addr_raw = base - block_span;
        endcase
    end

    assign block_addr = block_addr_raw & ALIGN_MASK;

    // ------------------------------------------------------------------
    // Block-transfer iteration
    // ------------------------------------------------------------------
    logic [REG_W-1:0]    pick_idx;
    logic [NUM_REGS-1:0] pick_rest;

    core_ldst_pick_lowest #(
        .N (NUM_REGS)
    ) u_pick (
        .mask (mask_reg),
        .idx  (pick_idx),
        .rest (pick_rest)
    );

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= LDST_IDLE;
            mask_reg      <= '0;
            addr_reg      <= '0;
            wb_value_reg  <= '0;
            wb_en_reg     <= 1'b0;
            rn_reg        <= '0;
            rd_reg        <= '0;
            size_reg      <= LDST_BYTE;
            load_reg      <= 1'b0;
            sext_reg      <= 1'b0;
            unpriv_reg    <= 1'b0;
            user_regs_reg <= 1'b0;
            multiple_reg  <= 1'b0;
        end else begin
            case (state_reg)
                LDST_IDLE: begin
                    if (start) begin
                        rn_reg        <= decode.rn[REG_W-1:0];
                        rd_reg        <= decode.rd[REG_W-1:0];
                        load_reg      <= decode.load;
                        unpriv_reg    <= decode.unprivileged;
                        user_regs_reg <= decode.user_regs;
                        multiple_reg  <= multiple;
                        if (multiple) begin
                            mask_reg     <= regs_in;
                            addr_reg     <= block_addr;
                            wb_value_reg <= block_wb;
                            size_reg     <= LDST_WORD;
                            sext_reg     <= 1'b0;
                            if (regs_in == '0) begin
                                // Nothing to move: complete without a
                                // request and without touching the base.
                                wb_en_reg <= 1'b0;
                                state_reg <= LDST_DONE;
                            end else begin
                                wb_en_reg <= decode.writeback;
                                state_reg <= LDST_XFER;
                            end
                        end else begin
                            mask_reg     <= '0;
                            addr_reg     <= single_addr;
                            wb_value_reg <= single_wb;
                            size_reg     <= decode.size;
                            sext_reg     <= decode.sign_extend;
                            wb_en_reg    <= decode.writeback;
                            state_reg    <= LDST_XFER;
                        end
                    end
                end

                LDST_XFER: begin
                    if (mem_ready) begin
                        if (multiple_reg) begin
                            mask_reg <= pick_rest;
                            addr_reg <= addr_reg + STRIDE;
                        end
                        if (!multiple_reg || (pick_rest == '0)) begin
                            state_reg <= LDST_DONE;
                        end
                    end
                end

                LDST_DONE: begin
                    state_reg <= LDST_IDLE;
                end

                default: begin
                    state_reg <= LDST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic xfer;
    assign xfer = (state_reg == LDST_XFER);

    assign start_ready = (state_reg == LDST_IDLE);

    // Request attributes are gated by mem_valid so the channel reads all-zero
    // when idle; while valid they come straight from registers and therefore
    // stay stable across a stall.
    assign mem_valid       = xfer;
    assign mem_addr        = xfer ? addr_reg : '0;
    assign mem_write       = xfer & ~load_reg;
    assign mem_size        = xfer ? size_reg : LDST_BYTE;
    assign mem_sign_extend = xfer & sext_reg;
    assign mem_user        = xfer & unpriv_reg;
    assign mem_reg         = xfer ? (multiple_reg ? pick_idx : rd_reg) : '0;
    assign mem_user_regs   = xfer & user_regs_reg;

    assign done     = (state_reg == LDST_DONE);
    assign wb_valid = done & wb_en_reg;
    assign wb_reg   = rn_reg;
    assign wb_value = wb_value_reg;

endmodule : core_ldst_sequencer

// File: tb/tb_core_ldst_sequencer.sv
// tb_core_ldst_sequencer
//   Drives directed and randomized transfers into core_ldst_sequencer and
//   compares every observed request and completion against a transfer-level
//   reference model (expected beat list, writeback value, completion cycle).
module tb_core_ldst_sequencer;
    import core_uarch_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int WB       = 4;
    localparam int REG_W    = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              start_ready;
    logic              multiple;
    ldst_decode        decode;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] offset;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    ldst_size          mem_size;
    logic              mem_sign_extend;
    logic              mem_user;
    logic [REG_W-1:0]  mem_reg;
    logic              mem_user_regs;
    logic              done;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic [ADDR_W-1:0] wb_value;

    core_ldst_sequencer #(
        .ADDR_W     (ADDR_W),
        .NUM_REGS   (NUM_REGS),
        .WORD_BYTES (WB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_ready     (start_ready),
        .multiple        (multiple),
        .decode          (decode),
        .base            (base),
        .offset          (offset),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_write       (mem_write),
        .mem_size        (mem_size),
        .mem_sign_extend (mem_sign_extend),
        .mem_user        (mem_user),
        .mem_reg         (mem_reg),
        .mem_user_regs   (mem_user_regs),
        .done            (done),
        .wb_valid        (wb_valid),
        .wb_reg          (wb_reg),
        .wb_value        (wb_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int txn_num  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        chk({tag, "_mem_valid"},   64'(mem_valid),   64'd0);
        chk({tag, "_mem_addr"},    64'(mem_addr),    64'd0);
        chk({tag, "_mem_write"},   64'(mem_write),   64'd0);
        chk({tag, "_mem_reg"},     64'(mem_reg),     64'd0);
        chk({tag, "_done"},        64'(done),        64'd0);
        chk({tag, "_wb_valid"},    64'(wb_valid),    64'd0);
        chk({tag, "_wb_value"},    64'(wb_value),    64'd0);
        chk({tag, "_wb_reg"},      64'(wb_reg),      64'd0);
    endtask

    // Randomly scramble the transfer inputs; used while the sequencer is busy
    // to show that a start outside IDLE is ignored.
    task automatic scramble_inputs();
        start          = 1'($urandom);
        multiple       = 1'($urandom);
        decode         = ldst_decode'({$urandom, $urandom});
        base           = $urandom;
        offset         = $urandom;
    endtask

    // Call at a negedge with the DUT in IDLE. Runs one whole transfer.
    task automatic run_xfer(input logic multi, input ldst_decode d,
                            input logic [31:0] b, input logic [31:0] off,
                            input int stall_first, input bit rand_stall,
                            input bit noise);
        logic [31:0] aq[$];
        int          rq[$];
        logic [31:0] exp_wb;
        logic        exp_wbv;
        ldst_size    exp_size;
        logic        exp_sext;
        logic [31:0] sum;
        logic [31:0] a;
        logic [31:0] span;
        int          n;
        int          beats;
        int          stalls;
        int          cyc;
        bit          done_seen;
        bit          rdy;

        // ---------------- reference model ----------------
        if (!multi) begin
            sum      = d.increment ? (b + off) : (b - off);
            aq.push_back(d.pre_indexed ? sum : b);
            rq.push_back(int'(d.rd));
            exp_wb   = sum;
            exp_wbv  = d.writeback;
            exp_size = d.size;
            exp_sext = d.sign_extend;
        end else begin
            n    = $countones(d.regs);
            span = 32'(WB * n);
            if (d.increment) a = d.pre_indexed ? b + 32'(WB) : b;
            else             a = d.pre_indexed ? b - span : b - span + 32'(WB);
            a = a & ~(32'(WB - 1));
            for (int i = 0; i < NUM_REGS; i++) begin
                if (d.regs[i]) begin
                    aq.push_back(a);
                    rq.push_back(i);
                    a = a + 32'(WB);
                end
            end
            exp_wb   = d.increment ? b + span : b - span;
            exp_wbv  = d.writeback && (n > 0);
            exp_size = LDST_WORD;
            exp_sext = 1'b0;
        end
        beats = aq.size();

        // ---------------- drive ----------------
        chk("start_ready_idle", 64'(start_ready), 64'd1);
        start     = 1'b1;
        multiple  = multi;
        decode    = d;
        base      = b;
        offset    = off;
        mem_ready = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;

        stalls    = 0;
        done_seen = 0;
        cyc       = 0;
        while (cyc < 300) begin
            if (aq.size() > 0) begin
                chk("mem_valid",   64'(mem_valid),       64'd1);
                chk("start_ready_busy", 64'(start_ready), 64'd0);
                chk("done_early",  64'(done),            64'd0);
                chk("mem_addr",    64'(mem_addr),        64'(aq[0]));
                chk("mem_reg",     64'(mem_reg),         64'(rq[0]));
                chk("mem_write",   64'(mem_write),       64'(!d.load));
                chk("mem_size",    64'(mem_size),        64'(exp_size));
                chk("mem_sext",    64'(mem_sign_extend), 64'(exp_sext));
                chk("mem_user",    64'(mem_user),        64'(d.unprivileged));
                chk("mem_user_regs", 64'(mem_user_regs), 64'(d.user_regs));
                if (cyc < stall_first)  rdy = 1'b0;
                else if (rand_stall)    rdy = ($urandom_range(0, 2) != 0);
                else                    rdy = 1'b1;
                mem_ready = rdy;
                if (noise) scramble_inputs();
                if (rdy) begin
                    void'(aq.pop_front());
                    void'(rq.pop_front());
                end else begin
                    stalls++;
                end
            end else begin
                chk("done",           64'(done),      64'd1);
                chk("done_cycle",     64'(cyc),       64'(beats + stalls));
                chk("mem_valid_done", 64'(mem_valid), 64'd0);
                chk("wb_valid",       64'(wb_valid),  64'(exp_wbv));
                if (exp_wbv) begin
                    chk("wb_reg",   64'(wb_reg),   64'(d.rn));
                    chk("wb_value", 64'(wb_value), 64'(exp_wb));
                end
                start     = 1'b0;
                mem_ready = 1'($urandom);
                done_seen = 1;
            end
            @(negedge clk);
            cyc++;
            if (done_seen) break;
        end
        if (!done_seen) chk("timeout_no_done", 64'd0, 64'd1);

        chk("start_ready_after", 64'(start_ready), 64'd1);
        chk("done_pulse",        64'(done),        64'd0);
        chk("wb_valid_after",    64'(wb_valid),    64'd0);
        txn_num++;
        $display("txn %0d multi=%0d base=0x%08h beats=%0d stalls=%0d wb_valid=%0d wb_value=0x%08h",
                 txn_num, multi, b, beats, stalls, exp_wbv, exp_wb);
    endtask

    function automatic ldst_decode mk_dec(input logic [3:0] rn, input logic [3:0] rd,
                                          input ldst_size sz, input logic ld,
                                          input logic inc, input logic wbk,
                                          input logic pre, input logic [15:0] regs);
        ldst_decode d;
        d              = '0;
        d.rn           = rn;
        d.rd           = rd;
        d.size         = sz;
        d.load         = ld;
        d.increment    = inc;
        d.writeback    = wbk;
        d.pre_indexed  = pre;
        d.regs         = regs;
        return d;
    endfunction

    initial begin
        ldst_decode d;
        logic [31:0] rb;
        logic [31:0] ro;
        logic        rm;

        rst_n     = 1'b0;
        start     = 1'b0;
        multiple  = 1'b0;
        decode    = '0;
        base      = '0;
        offset    = '0;
        mem_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single pre-indexed load.
        d = mk_dec(4'd5, 4'd3, LDST_WORD, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
        run_xfer(1'b0, d, 32'h1000, 32'h10, 0, 1'b0, 1'b0);

        // Single post-indexed decrement store, three stall cycles.
        d = mk_dec(4'd2, 4'd7, LDST_HALF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        d.sign_extend = 1'b1;
        run_xfer(1'b0, d, 32'h2000, 32'h8, 3, 1'b0, 1'b0);

        // Block increment-after.
        d = mk_dec(4'd13, 4'd0, LDST_BYTE, 1'b1, 1'b1, 1'b1, 1'b0, 16'h800F);
        run_xfer(1'b1, d, 32'h100, 32'hDEAD, 0, 1'b0, 1'b0);

        // Block decrement-before.
        d = mk_dec(4'd13, 4'd0, LDST_HALF, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0006);
        d.sign_extend = 1'b1;
        run_xfer(1'b1, d, 32'h200, 32'h0, 0, 1'b0, 1'b0);

        // Empty mask.
        d = mk_dec(4'd4, 4'd0, LDST_WORD, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        run_xfer(1'b1, d, 32'h300, 32'h0, 0, 1'b0, 1'b0);

        // Reset during the second of four beats.
        d = mk_dec(4'd9, 4'd0, LDST_WORD, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00F0);
        start     = 1'b1;
        multiple  = 1'b1;
        decode    = d;
        base      = 32'h400;
        offset    = 32'h0;
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("rst_beat1_valid", 64'(mem_valid), 64'd1);
        @(negedge clk);
        chk("rst_beat2_addr", 64'(mem_addr), 64'h404);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 64'(start_ready), 64'd1);
        chk("rst_release_done",  64'(done),        64'd0);
        d = mk_dec(4'd1, 4'd6, LDST_BYTE, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        run_xfer(1'b0, d, 32'h500, 32'h20, 0, 1'b0, 1'b0);

        // Randomized transfers with stalls and busy-time start noise.
        for (int t = 0; t < 40; t++) begin
            d             = ldst_decode'({$urandom, $urandom});
            d.size        = ldst_size'($urandom_range(0, 2));
            d.regs        = 16'($urandom & $urandom);
            if ($urandom_range(0, 7) == 0) d.regs = 16'h0;
            rb            = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            ro            = 32'($urandom_range(0, 4095));
            rm            = 1'($urandom);
            run_xfer(rm, d, rb, ro, int'($urandom_range(0, 2)), 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_core_ldst_sequencer
